con_arbiter: RTL and testbench
==============================

// Module: con_arbiter
// PURPOSE
//  Shares the core's protocol-controller datamem port (con_addr/con_write/con_in/con_out) between two
//  requesters: m0 = protocol controller (mcont), m1 = UART datamem dump. Sits in top between both
//  requesters and core; one access in flight at a time; round-robin, starvation-free.
// PARAMETERS
//  ADDR_W  11  datamem word-address width (con_addr)
//  DATA_W  32  data width; WE_W = DATA_W/8 byte enables
//  RD_LAT  1   datamem read latency in cycles from con_addr to valid con_out (>=1)
// PORTS
//  CLK        in   1       system clock (CLK_BUF); single clock domain
//  nrst       in   1       asynchronous active-low reset
//  mN_req     in   1       N=0,1: access request; hold with payload stable until mN_gnt
//  mN_lock    in   1       keep grant for back-to-back accesses (CONARB_LOCK_EN only)
//  mN_addr    in   ADDR_W  access address
//  mN_we      in   WE_W    byte write enables; all-zero = read
//  mN_wdata   in   DATA_W  write data
//  mN_gnt     out  1       one-cycle pulse: access launched
//  mN_rvalid  out  1       one-cycle pulse: mN_rdata holds read result
//  mN_rdata   out  DATA_W  read data (shared register; qualified by mN_rvalid)
//  con_addr   out  ADDR_W  to core datamem port
//  con_write  out  WE_W    to core; nonzero for exactly one cycle per write
//  con_in     out  DATA_W  write data to core
//  con_out    in   DATA_W  read data from core
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; last-served=m1 (m0 wins first tie); pending read dropped.
//  - FSM: IDLE -> ISSUE (any req) ; ISSUE -> WAIT (read) | IDLE (write) ; WAIT -> IDLE after RD_LAT cycles.
//  - IDLE: winner = sole requester, else requester != last-served. Payload registered onto con_*;
//    no req -> stay IDLE, con_write=0, con_addr/con_in hold last value.
//  - ISSUE (1 cycle): con_* driven, winner mN_gnt=1, last-served<=winner. Requester may drop req or
//    present a new payload from the next cycle.
//  - WAIT: con_write=0, con_addr held; con_out captured into rdata at end of final WAIT cycle;
//    winner mN_rvalid=1 in the following cycle (overlaps IDLE arbitration).
//  - Timing, RD_LAT=1 read: req@T -> gnt@T+1 -> capture@T+2 -> rvalid@T+3. Write: req@T -> gnt and
//    con_write@T+1 -> IDLE@T+2. Max issue rate: 1 write/2 cycles, 1 read/(3+RD_LAT-1) cycles.
//  - Reqs during ISSUE/WAIT ignored until IDLE; req dropped before gnt -> no access, no gnt.
//  - Simultaneous req: alternates strictly; a waiting requester waits at most one transaction.
//  - Reset mid-WAIT: no rvalid issued; outputs to 0 immediately (async).
//  - mN_gnt and mN_rvalid never both asserted for m0 and m1 in the same cycle.
// CONFIGURATION
//  CONARB_LOCK_EN defined: if winner had mN_lock=1 at ISSUE, next IDLE grants same requester when its
//   req=1, ignoring round-robin; lock released when lock=0 or req=0 at an IDLE decision.
//  Undefined: mN_lock ports present but ignored; pure round-robin.
// STRUCTURE
//  con_arbiter_pkg (header include): FSM state encodings (IDLE/ISSUE/WAIT), requester IDs
//   (REQ_M0/REQ_M1), RD_LAT counter width.
//  Sub-module rr_arb2: combinational 2-way round-robin pick (req[1:0], last, lock_hold) -> winner.
//  Top: FSM, con_* payload regs, RD_LAT down-counter, rdata/rvalid regs.
// TESTING
//  1 m0 write addr 0x010, we=4'hF, data 0xDEADBEEF -> m0_gnt@T+1, con_write=4'hF 1 cycle, con_addr=0x010.
//  2 m1 read 0x010 after (1) -> m1_gnt@T+1, m1_rvalid@T+3, m1_rdata=0xDEADBEEF; no m0 strobes.
//  3 m0,m1 req held 6 transactions -> grants m0,m1,m0,m1,...; first grant m0 after reset.
//  4 nrst low during WAIT of m1 read -> outputs 0 same cycle; no m1_rvalid after release; next grant m0.
//  5 CONARB_LOCK_EN, m1 lock=1, both req -> m1 granted 4 consecutive; m1 lock=0 -> next grant m0.
//   Without macro same stimulus -> strict alternation.
//  6 m0 req pulsed 1 cycle while m1 ISSUE -> no m0 gnt, no con_* activity for m0.

Source files
------------

// File: rtl/con_arbiter_pkg.sv
// con_arbiter_pkg: shared definitions for the datamem port arbiter.
//   - state_t   : arbiter FSM encodings (IDLE / ISSUE / WAIT)
//   - REQ_M0/M1 : requester identifiers (m0 = protocol controller, m1 = UART dump)
//   - RD_CNT_W  : width of the read-latency down-counter (RD_LAT up to 255)
package con_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  localparam int RD_CNT_W = 8;

endpackage

// File: rtl/con_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   req[1:0]  in  : request vector (bit N = requester N)
//   last      in  : requester served most recently
//   lock_hold in  : keep the last-served requester when it is still requesting
//   winner    out : chosen requester id (valid only when valid=1)
//   valid     out : at least one requester is asking
module rr_arb2
  import con_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_hold,
  output logic       winner,
  output logic       valid
);

  // Sole requester wins; on a tie the one not served last wins unless a lock holds it.
  always_comb begin
    winner = REQ_M0;
    valid  = 1'b0;
    case (req)
      2'b01: begin
        winner = REQ_M0;
        valid  = 1'b1;
      end
      2'b10: begin
        winner = REQ_M1;
        valid  = 1'b1;
      end
      2'b11: begin
        valid = 1'b1;
        if (lock_hold) begin
          winner = last;
        end else begin
          winner = ~last;
        end
      end
      default: begin
        winner = REQ_M0;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/con_arbiter.sv
// con_arbiter: shares the core datamem port between m0 (protocol controller)
// and m1 (UART datamem dump). One access in flight; round-robin, starvation-free.
// Optional feature macro: CONARB_LOCK_EN (grant lock for back-to-back accesses).
// Ports:
//   CLK, nrst                       clock, asynchronous active-low reset
//   mN_req/lock/addr/we/wdata  in   requester N access request and payload
//   mN_gnt                     out  one-cycle pulse, access launched
//   mN_rvalid / mN_rdata       out  read result strobe / shared read data register
//   con_addr/con_write/con_in  out  to core datamem port (registered)
//   con_out                    in   read data from core
module con_arbiter
  import con_arbiter_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                CLK,
  input  logic                nrst,
  input  logic                m0_req,
  input  logic                m0_lock,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_we,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_lock,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_we,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   con_addr,
  output logic [DATA_W/8-1:0] con_write,
  output logic [DATA_W-1:0]   con_in,
  input  logic [DATA_W-1:0]   con_out
);

  localparam int WE_W = DATA_W / 8;

`ifdef CONARB_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  state_t              state;
  logic                last;       // last-served requester
  logic                owner;      // requester of the access in flight
  logic                lock_hold;  // owner asked to keep the grant at ISSUE
  logic [RD_CNT_W-1:0] cnt;
  logic [DATA_W-1:0]   rdata;

  logic                last_req;
  logic                last_lock;
  logic                hold;
  logic                pick;
  logic                pick_valid;
  logic [ADDR_W-1:0]   win_addr;
  logic [WE_W-1:0]     win_we;
  logic [DATA_W-1:0]   win_wdata;

  assign last_req  = last ? m1_req  : m0_req;
  assign last_lock = last ? m1_lock : m0_lock;
  // A lock only survives while the locked requester still requests with lock set.
  assign hold      = lock_hold & last_lock & last_req & LOCK_EN;

  rr_arb2 u_rr_arb2 (
    .req       ({m1_req, m0_req}),
    .last      (last),
    .lock_hold (hold),
    .winner    (pick),
    .valid     (pick_valid)
  );

  assign win_addr  = pick ? m1_addr  : m0_addr;
  assign win_we    = pick ? m1_we    : m0_we;
  assign win_wdata = pick ? m1_wdata : m0_wdata;

  assign m0_rdata = rdata;
  assign m1_rdata = rdata;

  // Arbiter FSM with registered con_* payload, grant/rvalid strobes and read capture.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      last      <= REQ_M1;
      owner     <= REQ_M0;
      lock_hold <= 1'b0;
      cnt       <= {RD_CNT_W{1'b0}};
      rdata     <= {DATA_W{1'b0}};
      con_addr  <= {ADDR_W{1'b0}};
      con_write <= {WE_W{1'b0}};
      con_in    <= {DATA_W{1'b0}};
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      con_write <= {WE_W{1'b0}};
      case (state)
        ST_IDLE: begin
          lock_hold <= hold;
          if (pick_valid) begin
            state     <= ST_ISSUE;
            owner     <= pick;
            con_addr  <= win_addr;
            con_write <= win_we;
            con_in    <= win_wdata;
            m0_gnt    <= ~pick;
            m1_gnt    <= pick;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          last      <= owner;
          lock_hold <= owner ? m1_lock : m0_lock;
          if (con_write != {WE_W{1'b0}}) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_WAIT;
            cnt   <= RD_CNT_W'(RD_LAT - 1);
          end
        end
        ST_WAIT: begin
          if (cnt == {RD_CNT_W{1'b0}}) begin
            rdata     <= con_out;
            m0_rvalid <= ~owner;
            m1_rvalid <= owner;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - {{(RD_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_con_arbiter.sv
// tb_con_arbiter: directed self-checking bench for con_arbiter with a
// one-cycle-latency datamem model behind the con_* port.
module tb_con_arbiter;

  logic        CLK = 1'b0;
  logic        nrst;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [10:0] m0_addr, m1_addr;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [10:0] con_addr;
  logic [3:0]  con_write;
  logic [31:0] con_in;
  logic [31:0] con_out = 32'h0;

  logic [31:0] mem [0:2047];

  int total = 0;
  int bad   = 0;
  int g0 = 0, g1 = 0, r0 = 0, r1 = 0, wr = 0, excl = 0;

  con_arbiter dut (
    .CLK(CLK), .nrst(nrst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .con_addr(con_addr), .con_write(con_write), .con_in(con_in), .con_out(con_out)
  );

  always #5 CLK = ~CLK;

  // Datamem model: byte-enabled write, registered read (RD_LAT = 1).
  always @(posedge CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (con_write[b]) mem[con_addr][8*b +: 8] <= con_in[8*b +: 8];
    end
    con_out <= mem[con_addr];
  end

  // Strobe counters sampled away from the active edge.
  always @(negedge CLK) begin
    if (m0_gnt) g0++;
    if (m1_gnt) g1++;
    if (m0_rvalid) r0++;
    if (m1_rvalid) r1++;
    if (con_write != 4'h0) wr++;
    if ((m0_gnt && m1_gnt) || (m0_rvalid && m1_rvalid)) excl++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_m(input int m, input logic req, input logic [10:0] addr,
                       input logic [3:0] we, input logic [31:0] wd);
    if (m == 0) begin
      m0_req = req; m0_addr = addr; m0_we = we; m0_wdata = wd;
    end else begin
      m1_req = req; m1_addr = addr; m1_we = we; m1_wdata = wd;
    end
  endtask

  task automatic drop_all();
    m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nrst = 1'b1;
  endtask

  // Record the order of the next n grants (bit i = requester of grant i), bounded.
  task automatic collect(input int n, output logic [7:0] seq);
    int got = 0;
    int cyc = 0;
    seq = 8'h0;
    while (got < n && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (m0_gnt) begin seq[got] = 1'b0; got++; end
      else if (m1_gnt) begin seq[got] = 1'b1; got++; end
    end
    check("grant_count", got, n);
  endtask

  logic [7:0] seq;
  int         g0_s, g1_s, r0_s, r1_s, wr_s;

  initial begin
    drop_all();
    set_m(0, 1'b0, 11'h0, 4'h0, 32'h0);
    set_m(1, 1'b0, 11'h0, 4'h0, 32'h0);
    do_reset();

    // Reset state
    check("rst_con_addr", {21'h0, con_addr}, 32'h0);
    check("rst_con_write", {28'h0, con_write}, 32'h0);
    check("rst_con_in", con_in, 32'h0);
    check("rst_strobes", {28'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 32'h0);
    check("rst_rdata", m1_rdata, 32'h0);

    // 1: m0 write
    set_m(0, 1'b1, 11'h010, 4'hF, 32'hDEADBEEF);
    @(negedge CLK);
    check("w_gnt_T", {31'h0, m0_gnt}, 32'h0);
    @(negedge CLK);
    check("w_gnt_T1", {31'h0, m0_gnt}, 32'h1);
    check("w_con_write", {28'h0, con_write}, 32'hF);
    check("w_con_addr", {21'h0, con_addr}, 32'h010);
    check("w_con_in", con_in, 32'hDEADBEEF);
    @(posedge CLK);
    #1 m0_req = 1'b0;
    @(negedge CLK);
    check("w_con_write_T2", {28'h0, con_write}, 32'h0);
    check("w_gnt_T2", {31'h0, m0_gnt}, 32'h0);

    // 2: m1 read back
    g0_s = g0; r0_s = r0;
    @(posedge CLK);
    #1 set_m(1, 1'b1, 11'h010, 4'h0, 32'h0);
    @(negedge CLK);
    check("r_gnt_T", {31'h0, m1_gnt}, 32'h0);
    @(negedge CLK);
    check("r_gnt_T1", {31'h0, m1_gnt}, 32'h1);
    check("r_con_write", {28'h0, con_write}, 32'h0);
    check("r_con_addr", {21'h0, con_addr}, 32'h010);
    @(posedge CLK);
    #1 m1_req = 1'b0;
    @(negedge CLK);
    check("r_rvalid_T2", {31'h0, m1_rvalid}, 32'h0);
    @(negedge CLK);
    check("r_rvalid_T3", {31'h0, m1_rvalid}, 32'h1);
    check("r_rdata", m1_rdata, 32'hDEADBEEF);
    check("r_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    repeat (3) @(negedge CLK);
    check("r_no_m0_strobe", g0 - g0_s + r0 - r0_s, 32'h0);

    // 3: both requesting after reset -> strict alternation starting with m0
    do_reset();
    r1_s = r1;
    set_m(0, 1'b1, 11'h030, 4'hF, 32'h11223344);
    set_m(1, 1'b1, 11'h010, 4'h0, 32'h0);
    collect(6, seq);
    for (int i = 0; i < 6; i++) begin
      check("rr_grant", {31'h0, seq[i]}, (i % 2));
    end
    @(posedge CLK);
    #1 drop_all();
    repeat (5) @(negedge CLK);
    check("rr_m1_reads", r1 - r1_s, 32'd3);
    check("rr_m1_rdata", m1_rdata, 32'hDEADBEEF);

    // 4: reset during WAIT of an m1 read
    @(posedge CLK);
    #1 set_m(1, 1'b1, 11'h020, 4'h0, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    check("rw_gnt", {31'h0, m1_gnt}, 32'h1);
    check("rw_con_addr", {21'h0, con_addr}, 32'h020);
    @(posedge CLK);
    #1 m1_req = 1'b0;
    r1_s = r1;
    #2 nrst = 1'b0;
    #1;
    check("rw_async_addr", {21'h0, con_addr}, 32'h0);
    check("rw_async_strobes", {28'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 32'h0);
    repeat (2) @(posedge CLK);
    #1 nrst = 1'b1;
    repeat (4) @(negedge CLK);
    check("rw_no_rvalid", r1 - r1_s, 32'h0);
    check("rw_rdata", m1_rdata, 32'h0);
    @(posedge CLK);
    #1;
    set_m(0, 1'b1, 11'h060, 4'hF, 32'h0);
    set_m(1, 1'b1, 11'h061, 4'hF, 32'h0);
    collect(1, seq);
    check("rw_first_m0", {31'h0, seq[0]}, 32'h0);
    @(posedge CLK);
    #1 drop_all();
    repeat (3) @(posedge CLK);

    // 5: lock on m1
    do_reset();
    set_m(0, 1'b1, 11'h100, 4'hF, 32'hA0A0A0A0);
    set_m(1, 1'b1, 11'h101, 4'hF, 32'hB1B1B1B1);
    m1_lock = 1'b1;
    collect(5, seq);
`ifdef CONARB_LOCK_EN
    check("lock_seq", {27'h0, seq[4:0]}, 32'b11110);
`else
    check("lock_seq", {27'h0, seq[4:0]}, 32'b01010);
`endif
    @(posedge CLK);
    #1 m1_lock = 1'b0;
    collect(1, seq);
`ifdef CONARB_LOCK_EN
    check("lock_release", {31'h0, seq[0]}, 32'h0);
`else
    check("lock_release", {31'h0, seq[0]}, 32'h1);
`endif
    @(posedge CLK);
    #1 drop_all();
    repeat (3) @(posedge CLK);

    // 6: m0 pulse during m1 ISSUE is ignored
    g0_s = g0; g1_s = g1; wr_s = wr;
    #1 set_m(1, 1'b1, 11'h040, 4'hF, 32'hCAFEF00D);
    @(posedge CLK);
    #1;
    check("pulse_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    set_m(0, 1'b1, 11'h050, 4'hF, 32'h00000055);
    @(posedge CLK);
    #1 drop_all();
    repeat (6) @(negedge CLK);
    check("pulse_no_m0_gnt", g0 - g0_s, 32'h0);
    check("pulse_m1_gnts", g1 - g1_s, 32'h1);
    check("pulse_writes", wr - wr_s, 32'h1);
    check("pulse_con_addr", {21'h0, con_addr}, 32'h040);
    check("pulse_con_in", con_in, 32'hCAFEF00D);

    check("strobe_exclusive", excl, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
